rank_order_decoder: RTL and testbench
=====================================

RANK_ORDER_DECODER -- requirements
Module: rank_order_decoder

Interface
REQ-001 Parameter IMAGE_SIZE, 5, number of pixels per image.
REQ-002 Parameter IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), pixel-index width base.
REQ-003 Parameter PIXEL_MAX_VALUE, 10, intensity assigned to the first-ranked pixel.
REQ-004 Parameter PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), intensity width base.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 NEW_IMAGE  in  1  single-cycle pulse; clear and arm the decoder.
REQ-009 AERIN_REQ  in  1  asynchronous 4-phase AER request.
REQ-010 AERIN_ADDR  in  IMAGE_SIZE_BITS+1  pixel index; stable while AERIN_REQ is high.
REQ-011 AERIN_ACK  out  1  4-phase AER acknowledge, registered.
REQ-012 IMAGE  out  [PIXEL_BITS:0] x [0:IMAGE_SIZE-1]  reconstructed intensities.
REQ-013 INDICES_RECEIVED  out  IMAGE_SIZE_BITS+1  count of valid, distinct indices received.
REQ-014 IMAGE_DECODED  out  1  high while INDICES_RECEIVED == IMAGE_SIZE.
REQ-015 DUP_ERR  out  1  sticky; a repeated index was received.
REQ-016 ADDR_ERR  out  1  sticky; an index >= IMAGE_SIZE was received.

Function
REQ-017 AERIN_REQ SHALL pass through a 2-flop synchronizer; req_s is the second-stage output, and all FSM decisions SHALL use req_s.
REQ-018 The FSM SHALL have these states: IDLE, WAIT_REQ, CAPTURE, ACK.
REQ-019 IDLE: AERIN_ACK = 0 and req_s is ignored; NEW_IMAGE -> WAIT_REQ.
REQ-020 WAIT_REQ: when req_s = 1, the block SHALL latch AERIN_ADDR into addr_q and go to CAPTURE.
REQ-021 CAPTURE (one cycle): the block SHALL classify addr_q, update the storage, set AERIN_ACK = 1, and go to ACK.
REQ-022 ACK: AERIN_ACK is held at 1; on req_s = 0 the block SHALL clear AERIN_ACK and go to WAIT_REQ.
REQ-023 Latency: AERIN_ACK SHALL rise on the 2nd rising edge after the first cycle req_s = 1, and fall on the 1st rising edge after the first cycle req_s = 0.
REQ-024 Valid index (addr_q < IMAGE_SIZE and received bit clear), with rank r = current INDICES_RECEIVED:
  - IMAGE[addr_q] <= (r < PIXEL_MAX_VALUE) ? PIXEL_MAX_VALUE - r : 0;
  - set received[addr_q];
  - increment INDICES_RECEIVED.
REQ-025 Duplicate index (received bit set): no IMAGE or count change; DUP_ERR <= 1; the handshake still completes.
REQ-026 Out-of-range index (addr_q >= IMAGE_SIZE): no IMAGE or count change; ADDR_ERR <= 1; the handshake still completes.
REQ-027 Handshakes arriving while IMAGE_DECODED = 1 SHALL be acknowledged; in-range indices are then duplicates per REQ-025.
REQ-028 INDICES_RECEIVED SHALL saturate at IMAGE_SIZE and never wrap.
REQ-029 Unreceived pixels SHALL read 0; ranks >= PIXEL_MAX_VALUE SHALL write 0 (saturating subtract).
REQ-030 NEW_IMAGE in IDLE or WAIT_REQ: on the next edge, clear IMAGE, received, INDICES_RECEIVED, DUP_ERR and ADDR_ERR, and enter WAIT_REQ.
REQ-031 NEW_IMAGE in CAPTURE or ACK: set a pending flag; apply the clear on the ACK->WAIT_REQ transition and drop the flag. The in-flight event's effect is discarded by that clear.
REQ-032 NEW_IMAGE coincident with a clear already pending SHALL be merged into a single clear.
REQ-033 IMAGE_DECODED SHALL be combinational from INDICES_RECEIVED.

Reset
REQ-034 RSTN = 0 SHALL immediately, without a clock, force:
  - state = IDLE, AERIN_ACK = 0;
  - all IMAGE entries, received, INDICES_RECEIVED, DUP_ERR, ADDR_ERR, pending flag, addr_q = 0;
  - both synchronizer flops = 0.
REQ-035 Reset asserted mid-handshake SHALL drop AERIN_ACK asynchronously; after release the block waits in IDLE for NEW_IMAGE.

Verification (IMAGE_SIZE=5, PIXEL_MAX_VALUE=10)
REQ-036 Reset, then AERIN_REQ pulses without NEW_IMAGE -> AERIN_ACK stays 0, all outputs stay 0.
REQ-037 NEW_IMAGE, then indices 3,0,4,1,2 -> IMAGE = {9,7,6,10,8}, INDICES_RECEIVED = 5, IMAGE_DECODED = 1 one cycle after the 5th CAPTURE, no error flags.
REQ-038 Indices 2,2 -> IMAGE[2] = 10, INDICES_RECEIVED = 1, DUP_ERR = 1, both handshakes acknowledged.
REQ-039 Index 7 -> ADDR_ERR = 1, IMAGE all 0, AERIN_ACK follows REQ-023 timing exactly.
REQ-040 NEW_IMAGE pulsed while in ACK after index 1 -> once AERIN_REQ falls: INDICES_RECEIVED = 0, IMAGE[1] = 0, state WAIT_REQ.
REQ-041 RSTN dropped while AERIN_ACK = 1 -> AERIN_ACK = 0 within the same cycle; IMAGE_DECODED = 0 after release.

Source files
------------

// File: rtl/rank_order_decoder.sv
// rank_order_decoder
//   Rebuilds a small intensity image from a rank-order coded AER spike
//   stream. Each pixel index received over the 4-phase AER handshake gets
//   an intensity that falls with its arrival rank: the first index gets
//   PIXEL_MAX_VALUE, the next one less, and so on, saturating at 0.
//   Pixels that have not been received read 0.
//
// Ports
//   CLK              rising-edge clock
//   RSTN             asynchronous active-low reset
//   NEW_IMAGE        single-cycle pulse: clear the image and arm the decoder
//   AERIN_REQ        asynchronous 4-phase request (synchronised internally)
//   AERIN_ADDR       pixel index, stable while AERIN_REQ is high
//   AERIN_ACK        registered 4-phase acknowledge
//   IMAGE            reconstructed intensities, one entry per pixel
//   INDICES_RECEIVED number of valid, distinct indices received
//   IMAGE_DECODED    high while every pixel has been received
//   DUP_ERR          sticky: an index arrived twice
//   ADDR_ERR         sticky: an index >= IMAGE_SIZE arrived
module rank_order_decoder #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     NEW_IMAGE,
  input  logic                     AERIN_REQ,
  input  logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
  output logic                     AERIN_ACK,
  output logic [PIXEL_BITS:0]      IMAGE [0:IMAGE_SIZE-1],
  output logic [IMAGE_SIZE_BITS:0] INDICES_RECEIVED,
  output logic                     IMAGE_DECODED,
  output logic                     DUP_ERR,
  output logic                     ADDR_ERR
);

  localparam int IDX_W = IMAGE_SIZE_BITS + 1;
  localparam logic [IDX_W-1:0] SIZE_IDX = IDX_W'(IMAGE_SIZE);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    CAPTURE  = 2'd2,
    ACK      = 2'd3
  } state_t;

  // Intensity for arrival rank r: PIXEL_MAX_VALUE - r, floored at 0.
  function automatic logic [PIXEL_BITS:0] rank_value(input logic [IDX_W-1:0] r);
    int rank;
    int diff;
    rank = int'(r);
    if (rank < PIXEL_MAX_VALUE) begin
      diff = PIXEL_MAX_VALUE - rank;
    end else begin
      diff = 32'sd0;
    end
    return diff[PIXEL_BITS:0];
  endfunction

  logic                  sync_meta;
  logic                  req_s;
  state_t                state;
  state_t                next_state;
  logic                  ack_next;
  logic                  clear;
  logic                  latch;
  logic                  capture;
  logic                  set_pending;
  logic                  pending;
  logic [IDX_W-1:0]      addr_q;
  logic [IMAGE_SIZE-1:0] received;
  logic                  in_range;
  logic                  already;
  logic [PIXEL_BITS:0]   new_value;

  // Two-flop synchroniser for the asynchronous AER request.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_meta <= 1'b0;
      req_s     <= 1'b0;
    end else begin
      sync_meta <= AERIN_REQ;
      req_s     <= sync_meta;
    end
  end

  // Handshake state and registered acknowledge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      AERIN_ACK <= 1'b0;
    end else begin
      state     <= next_state;
      AERIN_ACK <= ack_next;
    end
  end

  // Next-state and control strobes for the handshake FSM.
  always_comb begin
    next_state  = state;
    ack_next    = AERIN_ACK;
    clear       = 1'b0;
    latch       = 1'b0;
    capture     = 1'b0;
    set_pending = 1'b0;
    case (state)
      IDLE: begin
        ack_next = 1'b0;
        if (NEW_IMAGE) begin
          clear      = 1'b1;
          next_state = WAIT_REQ;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_REQ: begin
        ack_next = 1'b0;
        // A clear takes priority; a held request is latched next cycle.
        if (NEW_IMAGE) begin
          clear      = 1'b1;
          next_state = WAIT_REQ;
        end else if (req_s) begin
          latch      = 1'b1;
          next_state = CAPTURE;
        end else begin
          next_state = WAIT_REQ;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        ack_next   = 1'b1;
        next_state = ACK;
        if (NEW_IMAGE) begin
          set_pending = 1'b1;
        end else begin
          set_pending = 1'b0;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_next   = 1'b0;
          next_state = WAIT_REQ;
          // Deferred clear lands as the handshake closes, wiping the
          // event that was in flight when NEW_IMAGE arrived.
          if (pending || NEW_IMAGE) begin
            clear = 1'b1;
          end else begin
            clear = 1'b0;
          end
        end else begin
          ack_next   = 1'b1;
          next_state = ACK;
          if (NEW_IMAGE) begin
            set_pending = 1'b1;
          end else begin
            set_pending = 1'b0;
          end
        end
      end
      default: begin
        next_state = IDLE;
        ack_next   = 1'b0;
      end
    endcase
  end

  // Classification of the latched index.
  always_comb begin
    in_range  = (addr_q < SIZE_IDX);
    already   = 1'b0;
    new_value = rank_value(INDICES_RECEIVED);
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (addr_q == IDX_W'(i)) begin
        already = received[i];
      end else begin
        already = already;
      end
    end
  end

  // Image storage, counters, sticky error flags and the deferred-clear flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        IMAGE[i] <= '0;
      end
      received         <= '0;
      INDICES_RECEIVED <= '0;
      DUP_ERR          <= 1'b0;
      ADDR_ERR         <= 1'b0;
      pending          <= 1'b0;
      addr_q           <= '0;
    end else if (clear) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        IMAGE[i] <= '0;
      end
      received         <= '0;
      INDICES_RECEIVED <= '0;
      DUP_ERR          <= 1'b0;
      ADDR_ERR         <= 1'b0;
      pending          <= 1'b0;
    end else begin
      if (set_pending) begin
        pending <= 1'b1;
      end
      if (latch) begin
        addr_q <= AERIN_ADDR;
      end
      if (capture) begin
        if (!in_range) begin
          ADDR_ERR <= 1'b1;
        end else if (already) begin
          DUP_ERR <= 1'b1;
        end else begin
          for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (addr_q == IDX_W'(i)) begin
              IMAGE[i]    <= new_value;
              received[i] <= 1'b1;
            end
          end
          // Count never passes IMAGE_SIZE.
          if (INDICES_RECEIVED != SIZE_IDX) begin
            INDICES_RECEIVED <= INDICES_RECEIVED + ONE_IDX;
          end
        end
      end
    end
  end

  assign IMAGE_DECODED = (INDICES_RECEIVED == SIZE_IDX);

endmodule

// File: tb/tb_rank_order_decoder.sv
module tb_rank_order_decoder;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       NEW_IMAGE;
  logic       AERIN_REQ;
  logic [3:0] AERIN_ADDR;
  logic       AERIN_ACK;
  logic [4:0] IMAGE [0:4];
  logic [3:0] INDICES_RECEIVED;
  logic       IMAGE_DECODED;
  logic       DUP_ERR;
  logic       ADDR_ERR;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  cnt;
    logic [24:0] img;
    logic        dup;
    logic        aerr;
  } exp_t;

  exp_t sb[$];

  rank_order_decoder dut (
    .CLK(CLK), .RSTN(RSTN), .NEW_IMAGE(NEW_IMAGE),
    .AERIN_REQ(AERIN_REQ), .AERIN_ADDR(AERIN_ADDR), .AERIN_ACK(AERIN_ACK),
    .IMAGE(IMAGE), .INDICES_RECEIVED(INDICES_RECEIVED),
    .IMAGE_DECODED(IMAGE_DECODED), .DUP_ERR(DUP_ERR), .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [24:0] pk(input int p0, input int p1, input int p2,
                                     input int p3, input int p4);
    return {5'(p4), 5'(p3), 5'(p2), 5'(p1), 5'(p0)};
  endfunction

  function automatic logic [24:0] flat_image();
    logic [24:0] f;
    for (int i = 0; i < 5; i++) f[5*i +: 5] = IMAGE[i];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each rising acknowledge presents one captured event.
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (AERIN_ACK && !ack_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(AERIN_ACK), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_count", 32'(INDICES_RECEIVED), 32'(e.cnt));
          chk("sb_image", 32'(flat_image()), 32'(e.img));
          chk("sb_dup", 32'(DUP_ERR), 32'(e.dup));
          chk("sb_addr_err", 32'(ADDR_ERR), 32'(e.aerr));
          chk("sb_decoded", 32'(IMAGE_DECODED), 32'(e.cnt == 4'd5));
        end
      end
      ack_prev = AERIN_ACK;
    end
  end

  task automatic push(input logic [3:0] c, input logic [24:0] im, input logic d, input logic a);
    exp_t e;
    e.cnt = c; e.img = im; e.dup = d; e.aerr = a;
    sb.push_back(e);
  endtask

  task automatic req_up(input logic [3:0] a);
    int n;
    AERIN_ADDR = a;
    AERIN_REQ  = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (AERIN_ACK) break;
    end
    chk("ack_rise_latency", 32'(n), 32'd4);
  endtask

  task automatic req_down();
    int n;
    AERIN_REQ = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (!AERIN_ACK) break;
    end
    chk("ack_fall_latency", 32'(n), 32'd3);
  endtask

  task automatic hs(input logic [3:0] a, input logic [3:0] c, input logic [24:0] im,
                    input logic d, input logic ae);
    push(c, im, d, ae);
    req_up(a);
    req_down();
  endtask

  task automatic new_image();
    NEW_IMAGE = 1'b1;
    @(posedge CLK); #1;
    NEW_IMAGE = 1'b0;
  endtask

  // Request pulse while disarmed: the acknowledge must never rise.
  task automatic idle_pulse(input string nm);
    int seen;
    seen = 0;
    AERIN_ADDR = 4'd3;
    AERIN_REQ  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (AERIN_ACK) seen++;
    end
    AERIN_REQ = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (AERIN_ACK) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; NEW_IMAGE = 1'b0; AERIN_REQ = 1'b0; AERIN_ADDR = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ack", 32'(AERIN_ACK), 32'd0);
    chk("rst_count", 32'(INDICES_RECEIVED), 32'd0);
    chk("rst_image", 32'(flat_image()), 32'd0);
    chk("rst_flags", 32'({IMAGE_DECODED, DUP_ERR, ADDR_ERR}), 32'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // Disarmed after reset: requests are ignored.
    idle_pulse("idle_no_ack");
    chk("idle_count", 32'(INDICES_RECEIVED), 32'd0);
    chk("idle_image", 32'(flat_image()), 32'd0);
    chk("idle_flags", 32'({IMAGE_DECODED, DUP_ERR, ADDR_ERR}), 32'd0);

    // Full image 3,0,4,1,2, then a duplicate and an out-of-range index.
    new_image();
    hs(4'd3, 4'd1, pk(0, 0, 0, 10, 0), 1'b0, 1'b0);
    hs(4'd0, 4'd2, pk(9, 0, 0, 10, 0), 1'b0, 1'b0);
    hs(4'd4, 4'd3, pk(9, 0, 0, 10, 8), 1'b0, 1'b0);
    hs(4'd1, 4'd4, pk(9, 7, 0, 10, 8), 1'b0, 1'b0);
    hs(4'd2, 4'd5, pk(9, 7, 6, 10, 8), 1'b0, 1'b0);
    hs(4'd0, 4'd5, pk(9, 7, 6, 10, 8), 1'b1, 1'b0);
    hs(4'd15, 4'd5, pk(9, 7, 6, 10, 8), 1'b1, 1'b1);

    // Duplicate index.
    new_image();
    chk("clear_count", 32'(INDICES_RECEIVED), 32'd0);
    chk("clear_flags", 32'({IMAGE_DECODED, DUP_ERR, ADDR_ERR}), 32'd0);
    hs(4'd2, 4'd1, pk(0, 0, 10, 0, 0), 1'b0, 1'b0);
    hs(4'd2, 4'd1, pk(0, 0, 10, 0, 0), 1'b1, 1'b0);

    // Out-of-range index.
    new_image();
    hs(4'd7, 4'd0, pk(0, 0, 0, 0, 0), 1'b0, 1'b1);

    // NEW_IMAGE while acknowledging: clear applied as the handshake closes.
    new_image();
    push(4'd1, pk(0, 10, 0, 0, 0), 1'b0, 1'b0);
    req_up(4'd1);
    new_image();
    req_down();
    chk("deferred_count", 32'(INDICES_RECEIVED), 32'd0);
    chk("deferred_image1", 32'(IMAGE[1]), 32'd0);
    hs(4'd4, 4'd1, pk(0, 0, 0, 0, 10), 1'b0, 1'b0);

    // Reset in the middle of a handshake.
    push(4'd2, pk(9, 0, 0, 0, 10), 1'b0, 1'b0);
    req_up(4'd0);
    @(negedge CLK); #1;
    RSTN = 1'b0;
    #1;
    chk("async_ack_drop", 32'(AERIN_ACK), 32'd0);
    AERIN_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_decoded", 32'(IMAGE_DECODED), 32'd0);
    chk("post_rst_count", 32'(INDICES_RECEIVED), 32'd0);
    chk("post_rst_image", 32'(flat_image()), 32'd0);
    idle_pulse("post_rst_idle");

    // Rearm and confirm normal operation.
    new_image();
    hs(4'd2, 4'd1, pk(0, 0, 10, 0, 0), 1'b0, 1'b0);

    repeat (4) @(posedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
